// File: rtl/int_mul_pkg.sv
// Shared types and constants for the sequential RV64M multiplier.
package int_mul_pkg;

    localparam int unsigned RISCV_ARCH      = 64;
    localparam int unsigned INT_MUL_LATENCY = 10;

    typedef struct packed {
        logic                         busy;
        logic [INT_MUL_LATENCY-1:0]   ena;
        logic                         rv32;
        logic                         high;
        logic                         invert;
        logic [RISCV_ARCH-1:0]        a1_mag;
        logic [RISCV_ARCH-1:0]        a2_shft;
        logic [2*RISCV_ARCH-1:0]      acc;
        logic [RISCV_ARCH-1:0]        result;
    } int_mul_registers;

    localparam int_mul_registers int_mul_r_reset = '0;

    // Magnitude of an operand; in 32-bit mode only the low word counts, upper bits zeroed.
    function automatic logic [RISCV_ARCH-1:0] mag64(input logic [RISCV_ARCH-1:0] v,
                                                    input logic neg,
                                                    input logic rv32);
        logic [31:0] lo;
        lo = v[31:0];
        if (rv32) begin
            return {32'b0, neg ? 32'(-lo) : lo};
        end
        return neg ? RISCV_ARCH'(-v) : v;
    endfunction

endpackage

// File: rtl/mulstage64.sv
// Combinational 64-bit by 4-bit partial product.
module mulstage64 (
    input  logic [63:0] i_a,
    input  logic [3:0]  i_nibble,
    output logic [67:0] o_pp
);

    assign o_pp = {4'b0, i_a} * {64'b0, i_nibble};

endmodule

// File: rtl/int_mul_seq.sv
// Sequential RV64M multiplier: magnitudes in, 8 multiplier bits per clock, sign restored at the end.
module int_mul_seq
    import int_mul_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ena,
    input  logic                  i_unsigned,
    input  logic                  i_hsu,
    input  logic                  i_high,
    input  logic                  i_rv32,
    input  logic [RISCV_ARCH-1:0] i_a1,
    input  logic [RISCV_ARCH-1:0] i_a2,
    output logic [RISCV_ARCH-1:0] o_res,
    output logic                  o_valid
);

    int_mul_registers r_q, r_d;

    logic                      accept_c;
    logic                      a1s_c, a2s_c;
    logic [2:0]                k_c;
    logic [67:0]               pp0_c, pp1_c;
    logic [71:0]               pp_sum_c;
    logic [2*RISCV_ARCH-1:0]   prod_c;

    mulstage64 u_stage0 (
        .i_a      (r_q.a1_mag),
        .i_nibble (r_q.a2_shft[3:0]),
        .o_pp     (pp0_c)
    );

    mulstage64 u_stage1 (
        .i_a      (r_q.a1_mag),
        .i_nibble (r_q.a2_shft[7:4]),
        .o_pp     (pp1_c)
    );

    always_comb begin
        r_d      = r_q;
        accept_c = i_ena && !r_q.busy;
        a1s_c    = !i_unsigned && (i_rv32 ? i_a1[31] : i_a1[63]);
        a2s_c    = !i_unsigned && !i_hsu && (i_rv32 ? i_a2[31] : i_a2[63]);
        pp_sum_c = 72'(pp0_c) + {pp1_c, 4'b0};
        prod_c   = r_q.invert ? (~r_q.acc + 128'd1) : r_q.acc;

        // Byte index of the current iteration follows the one-hot position in the shift register.
        k_c = 3'd0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (r_q.ena[i]) begin
                k_c = 3'(i);
            end
        end

        r_d.ena = {r_q.ena[INT_MUL_LATENCY-2:0], accept_c};

        if (accept_c) begin
            r_d.busy    = 1'b1;
            r_d.rv32    = i_rv32;
            r_d.high    = i_high;
            r_d.invert  = a1s_c ^ a2s_c;
            r_d.a1_mag  = mag64(i_a1, a1s_c, i_rv32);
            r_d.a2_shft = mag64(i_a2, a2s_c, i_rv32);
            r_d.acc     = '0;
        end else if (r_q.busy && !r_q.ena[INT_MUL_LATENCY-2]) begin
            r_d.acc     = r_q.acc + (128'(pp_sum_c) << {k_c, 3'b000});
            r_d.a2_shft = r_q.a2_shft >> 8;
        end else if (r_q.busy) begin
            r_d.busy = 1'b0;
            if (r_q.rv32) begin
                r_d.result = {{32{prod_c[31]}}, prod_c[31:0]};
            end else begin
                r_d.result = r_q.high ? prod_c[127:64] : prod_c[63:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= int_mul_r_reset;
        end else begin
            r_q <= r_d;
        end
    end

    assign o_res   = r_q.result;
    assign o_valid = r_q.ena[INT_MUL_LATENCY-1];

endmodule

// File: tb/tb_int_mul_seq.sv
// Self-checking bench for int_mul_seq: arithmetic reference model, per-cycle compare, directed literals.
module tb_int_mul_seq;

    logic        i_clk = 1'b0;
    logic        i_rst, i_ena, i_unsigned, i_hsu, i_high, i_rv32;
    logic [63:0] i_a1, i_a2;
    logic [63:0] o_res;
    logic        o_valid;

    int checks = 0;
    int errors = 0;

    int_mul_seq dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_ena      (i_ena),
        .i_unsigned (i_unsigned),
        .i_hsu      (i_hsu),
        .i_high     (i_high),
        .i_rv32     (i_rv32),
        .i_a1       (i_a1),
        .i_a2       (i_a2),
        .o_res      (o_res),
        .o_valid    (o_valid)
    );

    always #5 i_clk = ~i_clk;

    // Reference: sign/zero-extend operands to 130 bits and multiply.
    function automatic logic [63:0] ref_mul(input logic [63:0] a1, input logic [63:0] a2,
                                            input logic uns, input logic hsu,
                                            input logic high, input logic rv32);
        logic         s1, s2;
        logic [129:0] x, y, p;
        logic [31:0]  a1w, a2w;
        s1  = !uns;
        s2  = !uns && !hsu;
        a1w = a1[31:0];
        a2w = a2[31:0];
        if (rv32) begin
            x = {{98{s1 & a1w[31]}}, a1w};
            y = {{98{s2 & a2w[31]}}, a2w};
        end else begin
            x = {{66{s1 & a1[63]}}, a1};
            y = {{66{s2 & a2[63]}}, a2};
        end
        p = x * y;
        if (rv32) return {{32{p[31]}}, p[31:0]};
        return high ? p[127:64] : p[63:0];
    endfunction

    // Transaction-level model: one op in flight, result due 9 edges after accept.
    longint      cyc = 0;
    longint      free_at = 0;
    longint      due_at = 0;
    logic        pending = 1'b0;
    logic [63:0] pend_val = '0;
    logic [63:0] exp_res = '0;
    logic        exp_valid = 1'b0;

    always @(posedge i_clk) begin
        cyc = cyc + 1;
        if (i_rst) begin
            pending   = 1'b0;
            exp_res   = '0;
            exp_valid = 1'b0;
            free_at   = 0;
        end else begin
            exp_valid = pending && (due_at == cyc);
            if (exp_valid) begin
                exp_res = pend_val;
                pending = 1'b0;
            end
            if (i_ena && cyc >= free_at) begin
                pending  = 1'b1;
                due_at   = cyc + 9;
                free_at  = cyc + 10;
                pend_val = ref_mul(i_a1, i_a2, i_unsigned, i_hsu, i_high, i_rv32);
            end
        end
    end

    always @(negedge i_clk) begin
        if (cyc > 0) begin
            checks++;
            if (o_valid !== exp_valid || o_res !== exp_res) begin
                errors++;
                $display("FAIL model cyc=%0d valid=%b res=%h required valid=%b res=%h",
                         cyc, o_valid, o_res, exp_valid, exp_res);
            end
        end
    end

    task automatic idle();
        i_ena = 1'b0;
        i_unsigned = 1'b0;
        i_hsu = 1'b0;
        i_high = 1'b0;
        i_rv32 = 1'b0;
    endtask

    // Launch one op and wait for o_valid, checking result literal and latency.
    task automatic run_op(input string name, input logic [63:0] a1, input logic [63:0] a2,
                          input logic uns, input logic hsu, input logic high,
                          input logic rv32, input logic [63:0] want);
        int n;
        @(negedge i_clk);
        i_ena = 1'b1; i_a1 = a1; i_a2 = a2;
        i_unsigned = uns; i_hsu = hsu; i_high = high; i_rv32 = rv32;
        n = 0;
        @(negedge i_clk);
        idle();
        n = 1;
        while (!o_valid && n < 20) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (!o_valid || o_res !== want || n != 10) begin
            errors++;
            $display("FAIL %s res=%h lat=%0d required res=%h lat=10", name, o_res, n, want);
        end
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'h0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return {32'($urandom), 32'h8000_0000};
            4: return 64'($urandom_range(0, 255));
            default: return {32'($urandom), 32'($urandom)};
        endcase
    endfunction

    initial begin
        int pulses;
        int bad;
        i_rst = 1'b1; i_a1 = '0; i_a2 = '0;
        idle();
        repeat (3) @(negedge i_clk);
        checks++;
        if (o_res !== 64'h0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset res=%h valid=%b required res=0 valid=0", o_res, o_valid);
        end
        i_rst = 1'b0;

        run_op("mul_neg",    64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("mulhu_hi",   '1, '1, 1, 0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFE);
        run_op("mulhu_lo",   '1, '1, 1, 0, 0, 0, 64'h1);
        run_op("mulh_min",   64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 1, 0,
               64'h4000_0000_0000_0000);
        run_op("mul_min",    64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 64'h0);
        run_op("mulhsu",     '1, '1, 0, 1, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_op("mulw",       64'h1234_5678_0001_0000, 64'h8000, 0, 0, 0, 1, 64'hFFFF_FFFF_8000_0000);
        run_op("mul_zero",   64'h0, 64'h8000_0000_0000_0000, 0, 0, 1, 0, 64'h0);
        run_op("mulw_min",   64'h8000_0000, 64'hFFFF_FFFF, 0, 0, 1, 1, 64'hFFFF_FFFF_8000_0000);

        // i_ena held for 12 clocks: accepts at clk 0 and clk 10 only.
        @(negedge i_clk);
        i_a1 = 64'd3; i_a2 = 64'd5; i_ena = 1'b1;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge i_clk);
            if (i == 11) i_ena = 1'b0;
            if (o_valid) pulses++;
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL held_ena pulses=%0d required 2", pulses);
        end

        // Reset 5 clocks into an op: nothing comes out, result cleared.
        @(negedge i_clk);
        i_a1 = 64'd9; i_a2 = 64'd9; i_ena = 1'b1;
        @(negedge i_clk);
        i_ena = 1'b0;
        repeat (4) @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge i_clk);
            if (o_valid || o_res !== 64'h0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL mid_reset bad_cycles=%0d res=%h required 0 bad cycles res=0", bad, o_res);
        end
        run_op("after_rst", 64'd6, 64'hFFFF_FFFF_FFFF_FFF9, 0, 0, 0, 0, 64'hFFFF_FFFF_FFFF_FFD6);

        // Randomized traffic, including ena while busy and occasional reset.
        for (int i = 0; i < 2000; i++) begin
            @(negedge i_clk);
            i_ena      = ($urandom_range(0, 3) == 0);
            i_unsigned = 1'($urandom);
            i_hsu      = 1'($urandom);
            i_high     = 1'($urandom);
            i_rv32     = ($urandom_range(0, 3) == 0);
            i_a1       = pick_operand();
            i_a2       = pick_operand();
            i_rst      = ($urandom_range(0, 299) == 0);
        end
        @(negedge i_clk);
        i_rst = 1'b0;
        idle();
        repeat (12) @(negedge i_clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
